hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 3-stage RV32I core (Fetch | Decode/Execute (DE) | Memory/Writeback (MW)). It generates the 2-bit select for each operand's 3:1 forwarding mux. It freezes the pipeline while a load in MW waits on data memory. It squashes the wrong-path instructions after a taken branch, covering the one-cycle-latency synchronous instruction memory.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_dep_check.sv | 19 +
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the 3-stage pipeline hazard controller.
package hazard_pkg;

    // Controller states: normal issue, waiting on load data, squashing the wrong path
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LD_WAIT = 2'd1,
        FLUSH   = 2'd2
    } hz_state_t;

    // Forwarding-mux select encodings
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_ALU = 2'd1;
    localparam logic [1:0] FWD_LD  = 2'd2;

    // Source of the forwarded value for an instruction sitting in MW
    function automatic logic [1:0] fwd_select(input logic is_load);
        return is_load ? FWD_LD : FWD_ALU;
    endfunction

endpackage

// File: rtl/hazard_dep_check.sv
// Single-operand dependency check against the instruction in MW.
// Produces the hit flag and the forwarding select for that operand.
module hazard_dep_check
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       used,
    input  logic [4:0] rd,
    input  logic       reg_wr,
    input  logic       is_load,
    output logic       hit,
    output logic [1:0] sel
);

    // x0 is hardwired to zero, so a write to it is never forwarded
    assign hit = used & reg_wr & (rd != 5'd0) & (rd == rs);
    assign sel = hit ? fwd_select(is_load) : FWD_RF;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 3-stage RV32I core
// (Fetch | Decode/Execute | Memory/Writeback).
//  - forwarding selects for both DE operands
//  - global freeze while a load in MW waits on data memory
//  - two-cycle squash after a taken branch (synchronous imem adds one wrong-path fetch)
// Optional build macro: HAZARD_CTRL_PERF_EN enables freeze/flush cycle counters;
// without it the counter ports are tied to zero.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      de_rs1,
    input  logic [4:0]      de_rs2,
    input  logic            de_rs1_used,
    input  logic            de_rs2_used,
    input  logic [4:0]      mw_rd,
    input  logic            mw_reg_wr,
    input  logic            mw_is_load,
    input  logic            dmem_ready,
    input  logic            br_taken,
    output logic [1:0]      fwd_sel_a,
    output logic [1:0]      fwd_sel_b,
    output logic            stall_f,
    output logic            stall_de,
    output logic            stall_mw,
    output logic            flush_de,
    output logic [XLEN-1:0] perf_freeze_cnt,
    output logic [XLEN-1:0] perf_flush_cnt
);

    hz_state_t state_reg;
    hz_state_t state_next;

    logic            frz;
    logic [1:0][4:0] rs_vec;
    logic [1:0]      used_vec;
    logic [1:0]      hit_vec;
    logic [1:0][1:0] sel_vec;

    assign frz = mw_is_load & mw_reg_wr & ~dmem_ready;

    assign rs_vec[0]   = de_rs1;
    assign rs_vec[1]   = de_rs2;
    assign used_vec[0] = de_rs1_used;
    assign used_vec[1] = de_rs2_used;

    // Operand index 0 is A (rs1), index 1 is B (rs2)
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dep
            hazard_dep_check u_dep (
                .rs      (rs_vec[gi]),
                .used    (used_vec[gi]),
                .rd      (mw_rd),
                .reg_wr  (mw_reg_wr),
                .is_load (mw_is_load),
                .hit     (hit_vec[gi]),
                .sel     (sel_vec[gi])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: a freeze always wins; a branch in DE only acts once unfrozen
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN, LD_WAIT: begin
                if (frz) begin
                    state_next = LD_WAIT;
                end else if (br_taken) begin
                    state_next = FLUSH;
                end else begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                // DE holds a squashed fetch, so br_taken is meaningless here
                state_next = frz ? FLUSH : RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Mealy outputs; everything is forced quiet while reset is held
    always_comb begin
        stall_f   = 1'b0;
        stall_de  = 1'b0;
        stall_mw  = 1'b0;
        flush_de  = 1'b0;
        fwd_sel_a = FWD_RF;
        fwd_sel_b = FWD_RF;
        if (!rst) begin
            stall_f  = frz;
            stall_de = frz;
            stall_mw = frz;
            case (state_reg)
                RUN, LD_WAIT: begin
                    flush_de  = br_taken & ~frz;
                    fwd_sel_a = hit_vec[0] ? sel_vec[0] : FWD_RF;
                    fwd_sel_b = hit_vec[1] ? sel_vec[1] : FWD_RF;
                end
                FLUSH: begin
                    // Second wrong-path instruction: kill it, no forwarding to junk
                    flush_de = 1'b1;
                end
                default: begin
                    flush_de = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [XLEN-1:0] freeze_cnt_reg;
    logic [XLEN-1:0] flush_cnt_reg;

    // Free-running event counters, wrapping naturally at 2^XLEN
    always_ff @(posedge clk) begin
        if (rst) begin
            freeze_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            if (frz) begin
                freeze_cnt_reg <= freeze_cnt_reg + XLEN'(1);
            end
            if (flush_de) begin
                flush_cnt_reg <= flush_cnt_reg + XLEN'(1);
            end
        end
    end

    assign perf_freeze_cnt = freeze_cnt_reg;
    assign perf_flush_cnt  = flush_cnt_reg;
`else
    assign perf_freeze_cnt = '0;
    assign perf_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: forwarding, load freeze, branch squash,
// branch held under freeze, and reset out of LD_WAIT.
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      de_rs1, de_rs2;
    logic            de_rs1_used, de_rs2_used;
    logic [4:0]      mw_rd;
    logic            mw_reg_wr, mw_is_load, dmem_ready, br_taken;
    logic [1:0]      fwd_sel_a, fwd_sel_b;
    logic            stall_f, stall_de, stall_mw, flush_de;
    logic [XLEN-1:0] perf_freeze_cnt, perf_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .rst             (rst),
        .de_rs1          (de_rs1),
        .de_rs2          (de_rs2),
        .de_rs1_used     (de_rs1_used),
        .de_rs2_used     (de_rs2_used),
        .mw_rd           (mw_rd),
        .mw_reg_wr       (mw_reg_wr),
        .mw_is_load      (mw_is_load),
        .dmem_ready      (dmem_ready),
        .br_taken        (br_taken),
        .fwd_sel_a       (fwd_sel_a),
        .fwd_sel_b       (fwd_sel_b),
        .stall_f         (stall_f),
        .stall_de        (stall_de),
        .stall_mw        (stall_mw),
        .flush_de        (flush_de),
        .perf_freeze_cnt (perf_freeze_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        de_rs1 = 5'd0; de_rs2 = 5'd0; de_rs1_used = 1'b0; de_rs2_used = 1'b0;
        mw_rd = 5'd0; mw_reg_wr = 1'b0; mw_is_load = 1'b0; dmem_ready = 1'b1;
        br_taken = 1'b0;
    endtask

    task automatic show(input string tag);
        $display("[%0t] %s: rst=%0b br=%0b frz_in=%0b sel_a=%0d sel_b=%0d stall=%0b%0b%0b flush=%0b frzcnt=%0d flcnt=%0d",
                 $time, tag, rst, br_taken, mw_is_load & mw_reg_wr & ~dmem_ready, fwd_sel_a, fwd_sel_b,
                 stall_f, stall_de, stall_mw, flush_de, perf_freeze_cnt, perf_flush_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        mw_rd = 5'd7; mw_reg_wr = 1'b1; mw_is_load = 1'b1; dmem_ready = 1'b0;
        de_rs2 = 5'd7; de_rs2_used = 1'b1; br_taken = 1'b1;
        #2; show("reset held");
        checks++; if ({stall_f, stall_de, stall_mw} !== 3'b000) begin errors++; $display("FAIL reset_stall got=%b want=000", {stall_f, stall_de, stall_mw}); end
        checks++; if (flush_de !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b want=0", flush_de); end
        checks++; if (fwd_sel_b !== 2'd0) begin errors++; $display("FAIL reset_fwd_b got=%0d want=0", fwd_sel_b); end
        tick(); tick();
        rst = 1'b0; idle(); #2; show("reset released");
        checks++; if (perf_freeze_cnt !== '0) begin errors++; $display("FAIL reset_frzcnt got=%0d want=0", perf_freeze_cnt); end
        checks++; if (perf_flush_cnt !== '0) begin errors++; $display("FAIL reset_flcnt got=%0d want=0", perf_flush_cnt); end
        checks++; if ({stall_f, flush_de} !== 2'b00) begin errors++; $display("FAIL reset_idle got=%b want=00", {stall_f, flush_de}); end
        tick();
    endtask

    task automatic test_fwd();
        idle();
        mw_rd = 5'd5; mw_reg_wr = 1'b1; de_rs1 = 5'd5; de_rs2 = 5'd6; de_rs1_used = 1'b1; de_rs2_used = 1'b1;
        #2; show("alu fwd");
        checks++; if ({fwd_sel_a, fwd_sel_b} !== 4'b0100) begin errors++; $display("FAIL alu_fwd got a=%0d b=%0d want a=1 b=0", fwd_sel_a, fwd_sel_b); end
        checks++; if ({stall_f, stall_de, stall_mw} !== 3'b000) begin errors++; $display("FAIL alu_nostall got=%b want=000", {stall_f, stall_de, stall_mw}); end
        de_rs2 = 5'd5; #2; show("alu fwd both");
        checks++; if (fwd_sel_b !== 2'd1) begin errors++; $display("FAIL alu_fwd_b got=%0d want=1", fwd_sel_b); end
        de_rs2_used = 1'b0; #2; show("rs2 unused");
        checks++; if (fwd_sel_b !== 2'd0) begin errors++; $display("FAIL unused_b got=%0d want=0", fwd_sel_b); end
        mw_is_load = 1'b1; dmem_ready = 1'b1; #2; show("load ready fwd");
        checks++; if ({fwd_sel_a, stall_f} !== 3'b100) begin errors++; $display("FAIL ld_ready got a=%0d stall=%b want a=2 stall=0", fwd_sel_a, stall_f); end
        mw_reg_wr = 1'b0; mw_is_load = 1'b0; #2; show("no reg write");
        checks++; if (fwd_sel_a !== 2'd0) begin errors++; $display("FAIL nowr_a got=%0d want=0", fwd_sel_a); end
        mw_reg_wr = 1'b1; mw_rd = 5'd0; de_rs1 = 5'd0; #2; show("x0 guard");
        checks++; if (fwd_sel_a !== 2'd0) begin errors++; $display("FAIL x0_guard got=%0d want=0", fwd_sel_a); end
        tick();
    endtask

    task automatic test_load_wait();
        idle();
        mw_rd = 5'd7; mw_reg_wr = 1'b1; mw_is_load = 1'b1; dmem_ready = 1'b0;
        de_rs1 = 5'd3; de_rs1_used = 1'b1; de_rs2 = 5'd7; de_rs2_used = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2; show("load wait");
            checks++; if ({stall_f, stall_de, stall_mw, flush_de} !== 4'b1110) begin errors++; $display("FAIL ldwait_stall cyc=%0d got=%b want=1110", i, {stall_f, stall_de, stall_mw, flush_de}); end
            tick();
        end
        dmem_ready = 1'b1; #2; show("load release");
        checks++; if ({stall_f, stall_de, stall_mw} !== 3'b000) begin errors++; $display("FAIL ldrel_stall got=%b want=000", {stall_f, stall_de, stall_mw}); end
        checks++; if ({fwd_sel_a, fwd_sel_b} !== 4'b0010) begin errors++; $display("FAIL ldrel_fwd got a=%0d b=%0d want a=0 b=2", fwd_sel_a, fwd_sel_b); end
        checks++; if (perf_freeze_cnt !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL ldrel_frzcnt got=%0d want=%0d", perf_freeze_cnt, PERF ? 3 : 0); end
        tick();
        idle(); #2; show("after load");
        checks++; if ({stall_f, flush_de} !== 2'b00) begin errors++; $display("FAIL after_load got=%b want=00", {stall_f, flush_de}); end
        tick();
    endtask

    task automatic test_branch();
        idle();
        mw_rd = 5'd5; mw_reg_wr = 1'b1; de_rs1 = 5'd5; de_rs1_used = 1'b1; br_taken = 1'b1;
        #2; show("branch cyc0");
        checks++; if ({flush_de, stall_f, fwd_sel_a} !== 4'b1001) begin errors++; $display("FAIL br_cyc0 got flush=%b stall=%b a=%0d want 1 0 1", flush_de, stall_f, fwd_sel_a); end
        tick();
        br_taken = 1'b0; #2; show("branch cyc1");
        checks++; if ({flush_de, fwd_sel_a} !== 3'b100) begin errors++; $display("FAIL br_cyc1 got flush=%b a=%0d want 1 0", flush_de, fwd_sel_a); end
        tick();
        #2; show("branch cyc2");
        checks++; if ({flush_de, fwd_sel_a} !== 3'b001) begin errors++; $display("FAIL br_cyc2 got flush=%b a=%0d want 0 1", flush_de, fwd_sel_a); end
        checks++; if (perf_flush_cnt !== (PERF ? 32'd2 : 32'd0)) begin errors++; $display("FAIL br_flcnt got=%0d want=%0d", perf_flush_cnt, PERF ? 2 : 0); end
        tick();
    endtask

    task automatic test_branch_freeze();
        idle();
        mw_rd = 5'd9; mw_reg_wr = 1'b1; mw_is_load = 1'b1; dmem_ready = 1'b0; br_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2; show("branch frozen");
            checks++; if ({stall_f, stall_de, stall_mw, flush_de} !== 4'b1110) begin errors++; $display("FAIL brfrz_hold cyc=%0d got=%b want=1110", i, {stall_f, stall_de, stall_mw, flush_de}); end
            tick();
        end
        dmem_ready = 1'b1; #2; show("branch release");
        checks++; if ({stall_f, flush_de} !== 2'b01) begin errors++; $display("FAIL brfrz_rel got=%b want=01", {stall_f, flush_de}); end
        tick();
        mw_is_load = 1'b0; #2; show("branch flush2");
        checks++; if (flush_de !== 1'b1) begin errors++; $display("FAIL brfrz_fl2 got=%b want=1", flush_de); end
        tick();
        br_taken = 1'b0; #2; show("branch done");
        checks++; if (flush_de !== 1'b0) begin errors++; $display("FAIL brfrz_done got=%b want=0", flush_de); end
        checks++; if (perf_flush_cnt !== (PERF ? 32'd4 : 32'd0)) begin errors++; $display("FAIL brfrz_flcnt got=%0d want=%0d", perf_flush_cnt, PERF ? 4 : 0); end
        checks++; if (perf_freeze_cnt !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL brfrz_frzcnt got=%0d want=%0d", perf_freeze_cnt, PERF ? 5 : 0); end
        tick();
    endtask

    task automatic test_reset_ldwait();
        idle();
        mw_rd = 5'd7; mw_reg_wr = 1'b1; mw_is_load = 1'b1; dmem_ready = 1'b0; de_rs2 = 5'd7; de_rs2_used = 1'b1;
        #2; show("freeze before reset");
        checks++; if (stall_mw !== 1'b1) begin errors++; $display("FAIL rstld_frz got=%b want=1", stall_mw); end
        tick();
        rst = 1'b1; #2; show("reset in ld_wait");
        checks++; if ({stall_f, stall_de, stall_mw, flush_de, fwd_sel_b} !== 6'b000000) begin errors++; $display("FAIL rstld_held got=%b want=000000", {stall_f, stall_de, stall_mw, flush_de, fwd_sel_b}); end
        checks++; if (perf_freeze_cnt !== (PERF ? 32'd6 : 32'd0)) begin errors++; $display("FAIL rstld_precnt got=%0d want=%0d", perf_freeze_cnt, PERF ? 6 : 0); end
        tick();
        rst = 1'b0; idle(); #2; show("after reset");
        checks++; if ({stall_f, stall_de, stall_mw, flush_de, fwd_sel_a, fwd_sel_b} !== 8'd0) begin errors++; $display("FAIL rstld_out got=%b want=00000000", {stall_f, stall_de, stall_mw, flush_de, fwd_sel_a, fwd_sel_b}); end
        checks++; if ({perf_freeze_cnt, perf_flush_cnt} !== '0) begin errors++; $display("FAIL rstld_cnt got frz=%0d fl=%0d want 0 0", perf_freeze_cnt, perf_flush_cnt); end
        br_taken = 1'b1; #2; show("branch after reset");
        checks++; if (flush_de !== 1'b1) begin errors++; $display("FAIL rstld_run got=%b want=1", flush_de); end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_fwd();
        test_load_wait();
        test_branch();
        test_branch_freeze();
        test_reset_ldwait();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
